// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  // One captured port request.
  typedef struct packed {
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
    logic [1:0]         mask;
  } req_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Two-requester grant logic, one-hot output.
// Default: round-robin using a last-grant flop (resets to port 1 so port 0
// wins the first contest). With SRAM_ARBITER_FIXED_PRIO_EN defined, port 0
// always wins and the last-grant flop does not exist.
module sram_arb_grant (
`ifndef SRAM_ARBITER_FIXED_PRIO_EN
  input  logic       CLK,
  input  logic       reset,
  input  logic       adv,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef SRAM_ARBITER_FIXED_PRIO_EN
  // Port 0 has absolute priority.
  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  logic last_q, last_d;

  // On a tie the port not served last wins; a lone requester always wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  // Remember which port was granted whenever a grant is taken.
  always_comb begin
    last_d = last_q;
    if (adv) last_d = gnt[1];
  end

  // Last-grant register.
  always_ff @(posedge CLK) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an asynchronous 16-bit SRAM.
// IDLE -> ACCESS (WAIT_CYCLES cycles) -> RECOVER (1 cycle) -> IDLE.
// Optional macro SRAM_ARBITER_FIXED_PRIO_EN selects fixed priority (port 0).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2  // strobe length, legal 1..15
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               p0_valid,
  output logic               p0_ready,
  input  logic               p0_we,
  input  logic [SRAM_AW-1:0] p0_addr,
  input  logic [SRAM_DW-1:0] p0_wdata,
  input  logic [1:0]         p0_mask,
  output logic               p0_rsp_valid,
  output logic [SRAM_DW-1:0] p0_rdata,
  input  logic               p1_valid,
  output logic               p1_ready,
  input  logic               p1_we,
  input  logic [SRAM_AW-1:0] p1_addr,
  input  logic [SRAM_DW-1:0] p1_wdata,
  input  logic [1:0]         p1_mask,
  output logic               p1_rsp_valid,
  output logic [SRAM_DW-1:0] p1_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [SRAM_DW-1:0] sram_dat_read,
  output logic [SRAM_DW-1:0] sram_dat_write,
  output logic               sram_dat_writeEnable,
  output logic               sram_cs,
  output logic               sram_we,
  output logic               sram_oe,
  output logic               sram_ub,
  output logic               sram_lb
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  req_t                    req_q, req_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0][SRAM_DW-1:0] rdata_q, rdata_d;

  logic [1:0] req_vld, gnt;
  logic       accept, in_acc, in_rec;
  req_t       req0, req1;

  assign req_vld = {p1_valid, p0_valid};
  assign accept  = (state_q == ST_IDLE) && (|req_vld) && !reset;
  assign in_acc  = (state_q == ST_ACCESS);
  assign in_rec  = (state_q == ST_RECOVER) && !reset;
  assign req0    = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, mask: p0_mask};
  assign req1    = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, mask: p1_mask};

  sram_arb_grant u_grant (
`ifndef SRAM_ARBITER_FIXED_PRIO_EN
    .CLK   (CLK),
    .reset (reset),
    .adv   (accept),
`endif
    .req   (req_vld),
    .gnt   (gnt)
  );

  // Next-state, request capture, wait counter and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    gnt_d   = gnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_vld) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_INIT;
          gnt_d   = gnt;
          req_d   = gnt[1] ? req1 : req0;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RECOVER;
          // Sample the bus on the last strobe cycle, when data has settled.
          if (!req_q.we) rdata_d[gnt_q[1]] = sram_dat_read;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight access.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      gnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Handshakes and responses.
  assign p0_ready     = accept && gnt[0];
  assign p1_ready     = accept && gnt[1];
  assign p0_rsp_valid = in_rec && gnt_q[0];
  assign p1_rsp_valid = in_rec && gnt_q[1];
  assign p0_rdata     = rdata_q[0];
  assign p1_rdata     = rdata_q[1];

  // SRAM pins: address/data come straight from the captured request so they
  // stay put through ACCESS and RECOVER; strobes only assert during ACCESS.
  assign sram_addr            = req_q.addr;
  assign sram_dat_write       = req_q.wdata;
  assign sram_dat_writeEnable = in_acc && req_q.we;
  assign sram_cs              = !in_acc;
  assign sram_we              = !(in_acc && req_q.we);
  assign sram_oe              = !(in_acc && !req_q.we);
  assign sram_ub              = !(in_acc && req_q.mask[1]);
  assign sram_lb              = !(in_acc && req_q.mask[0]);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them when rsp_valid appears.
module tb_sram_arbiter;

  logic CLK = 1'b0, reset = 1'b1;
  always #5 CLK = ~CLK;

  // DUT A (WAIT_CYCLES=2)
  logic p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
  logic [17:0] p0_addr = 0, p1_addr = 0;
  logic [15:0] p0_wdata = 0, p1_wdata = 0;
  logic [1:0]  p0_mask = 0, p1_mask = 0;
  logic p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_dat_read, sram_dat_write;
  logic sram_dat_writeEnable, sram_cs, sram_we, sram_oe, sram_ub, sram_lb;

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .CLK(CLK), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_mask(p0_mask), .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_mask(p1_mask), .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
    .sram_addr(sram_addr), .sram_dat_read(sram_dat_read), .sram_dat_write(sram_dat_write),
    .sram_dat_writeEnable(sram_dat_writeEnable), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_oe(sram_oe), .sram_ub(sram_ub), .sram_lb(sram_lb)
  );

  // DUT B (WAIT_CYCLES=1), port 0 only
  logic b_valid = 0;
  logic [17:0] b_addr = 0;
  logic b_ready, b_rsp_valid, b1_ready, b1_rsp_valid;
  logic [15:0] b_rdata, b1_rdata;
  logic [17:0] b_sram_addr;
  logic [15:0] b_dat_read, b_dat_write;
  logic b_wen, b_cs, b_we, b_oe, b_ub, b_lb;

  sram_arbiter #(.WAIT_CYCLES(1)) dut_b (
    .CLK(CLK), .reset(reset),
    .p0_valid(b_valid), .p0_ready(b_ready), .p0_we(1'b0), .p0_addr(b_addr),
    .p0_wdata(16'h0), .p0_mask(2'b11), .p0_rsp_valid(b_rsp_valid), .p0_rdata(b_rdata),
    .p1_valid(1'b0), .p1_ready(b1_ready), .p1_we(1'b0), .p1_addr(18'h0),
    .p1_wdata(16'h0), .p1_mask(2'b00), .p1_rsp_valid(b1_rsp_valid), .p1_rdata(b1_rdata),
    .sram_addr(b_sram_addr), .sram_dat_read(b_dat_read), .sram_dat_write(b_dat_write),
    .sram_dat_writeEnable(b_wen), .sram_cs(b_cs), .sram_we(b_we),
    .sram_oe(b_oe), .sram_ub(b_ub), .sram_lb(b_lb)
  );

  // SRAM models: A is a small byte-masked memory, B returns 0x0F0F ^ addr.
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  always @(posedge CLK)
    if (!sram_cs && !sram_we) begin
      if (!sram_lb) mem[sram_addr[7:0]][7:0]  <= sram_dat_write[7:0];
      if (!sram_ub) mem[sram_addr[7:0]][15:8] <= sram_dat_write[15:8];
    end
  assign sram_dat_read = (!sram_cs && !sram_oe) ? mem[sram_addr[7:0]] : 16'hDEAD;
  assign b_dat_read    = (!b_cs && !b_oe) ? (16'h0F0F ^ b_sram_addr[15:0]) : 16'hDEAD;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          dut;
    int          port;
    bit          rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  // Response monitor
  logic [1:0][1:0]       rv;
  logic [1:0][1:0][15:0] rdv;
  assign rv[0]  = {p1_rsp_valid, p0_rsp_valid};
  assign rv[1]  = {b1_rsp_valid, b_rsp_valid};
  assign rdv[0] = {p1_rdata, p0_rdata};
  assign rdv[1] = {b1_rdata, b_rdata};
  int   m_idx;
  exp_t m_e;
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (rv[d][p]) begin
          m_idx = -1;
          for (int i = 0; i < sbq.size(); i++)
            if (m_idx < 0 && sbq[i].dut == d) m_idx = i;
          if (m_idx < 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected: dut=%0d port=%0d cyc=%0d", d, p, cyc);
          end else begin
            m_e = sbq[m_idx];
            sbq.delete(m_idx);
            chk("rsp_port", p, m_e.port);
            chk("rsp_cycle", cyc, m_e.cyc);
            if (m_e.rd) chk("rsp_rdata", rdv[d][p], m_e.data);
          end
        end
  end

  // DUT B read-strobe width monitor
  int oe_w = 0;
  always @(negedge CLK) begin
    if (!b_oe) oe_w++;
    else if (oe_w > 0) begin
      chk("b_oe_width", oe_w, 1);
      oe_w = 0;
    end
  end

  task automatic drive(input int p, input logic v, input logic we, input logic [17:0] a,
                       input logic [15:0] wd, input logic [1:0] m);
    if (p == 0) begin p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = wd; p0_mask = m; end
    else        begin p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = wd; p1_mask = m; end
  endtask

  // One transaction on DUT A with strobe checks through ACCESS and RECOVER.
  task automatic do_txn(input int p, input logic we, input logic [17:0] a,
                        input logic [15:0] wd, input logic [1:0] m, input logic [15:0] exp_rd);
    bit got = 0;
    @(posedge CLK); #1;
    drive(p, 1'b1, we, a, wd, m);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (p == 0 ? p0_ready : p1_ready) got = 1;
    end
    chk("accept_timeout", got, 1);
    sbq.push_back('{0, p, !we, exp_rd, cyc + 3});
    @(posedge CLK); #1;
    drive(p, 1'b0, we, a, wd, m);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("acc_cs", sram_cs, 0);
      chk("acc_we", sram_we, !we);
      chk("acc_oe", sram_oe, we);
      chk("acc_wen", sram_dat_writeEnable, we);
      chk("acc_ub", sram_ub, !m[1]);
      chk("acc_lb", sram_lb, !m[0]);
      chk("acc_addr", sram_addr, a);
      chk("acc_ready", p0_ready | p1_ready, 0);
      if (we) chk("acc_wdata", sram_dat_write, wd);
    end
    @(negedge CLK);
    chk("rec_strobes", {sram_cs, sram_we, sram_oe, sram_ub, sram_lb, sram_dat_writeEnable}, 6'b111110);
    chk("rec_addr", sram_addr, a);
  endtask

  int exp_rr[4];
  int t, prev, pp;
  bit got;

  initial begin
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 0, 1};
`endif
    repeat (3) @(posedge CLK);
    #1 reset = 0;
    @(negedge CLK);
    chk("rst_strobes", {sram_cs, sram_we, sram_oe, sram_ub, sram_lb, sram_dat_writeEnable}, 6'b111110);
    chk("rst_ready", {p0_ready, p1_ready}, 0);
    chk("rst_rsp", {p0_rsp_valid, p1_rsp_valid}, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dat_write", sram_dat_write, 0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 0);

    do_txn(0, 1'b1, 18'h00010, 16'hA5C3, 2'b11, 16'h0);
    do_txn(1, 1'b0, 18'h00010, 16'h0,    2'b11, 16'hA5C3);
    do_txn(0, 1'b1, 18'h00020, 16'h1234, 2'b01, 16'h0);
    do_txn(0, 1'b0, 18'h00020, 16'h0,    2'b11, 16'h0034);
    chk("p1_rdata_hold", p1_rdata, 16'hA5C3);

    // Reset in the 2nd ACCESS cycle; p1 waits and must be taken right after.
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b1, 18'h00030, 16'hBEEF, 2'b11);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (p0_ready) got = 1;
    end
    chk("rst_txn_accept", got, 1);
    @(posedge CLK); #1;
    drive(0, 1'b0, 1'b0, 18'h0, 16'h0, 2'b00);
    drive(1, 1'b1, 1'b1, 18'h00040, 16'h5555, 2'b11);
    @(posedge CLK); #1 reset = 1;
    @(posedge CLK); #1 reset = 0;
    @(negedge CLK);
    chk("midrst_strobes", {sram_cs, sram_we, sram_oe, sram_ub, sram_lb, sram_dat_writeEnable}, 6'b111110);
    chk("midrst_rsp", {p0_rsp_valid, p1_rsp_valid}, 0);
    chk("midrst_accept", p1_ready, 1);
    chk("midrst_rdata", p1_rdata, 0);
    if (p1_ready) sbq.push_back('{0, 1, 0, 16'h0, cyc + 3});
    @(posedge CLK); #1;
    drive(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b00);
    repeat (4) @(negedge CLK);

    // Both ports requesting continuously.
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b0, 18'h00010, 16'h0, 2'b11);
    drive(1, 1'b1, 1'b0, 18'h00020, 16'h0, 2'b11);
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge CLK);
        if (p0_ready || p1_ready) got = 1;
      end
      chk("rr_timeout", got, 1);
      chk("rr_onehot", p0_ready & p1_ready, 0);
      pp = p1_ready ? 1 : 0;
      chk("rr_grant", pp, exp_rr[k]);
      sbq.push_back('{0, pp, 1, (pp == 1) ? 16'h0034 : 16'hA5C3, cyc + 3});
    end
    @(posedge CLK); #1;
    drive(0, 1'b0, 1'b0, 18'h0, 16'h0, 2'b00);
    drive(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b00);
    repeat (4) @(negedge CLK);

    // WAIT_CYCLES=1: back-to-back reads on port 0.
    @(posedge CLK); #1;
    b_valid = 1; b_addr = 18'h00005;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge CLK);
        if (b_ready) got = 1;
      end
      chk("b_timeout", got, 1);
      t = cyc;
      if (k > 0) chk("b_accept_gap", t - prev, 3);
      prev = t;
      sbq.push_back('{1, 0, 1, 16'h0F0A, t + 2});
    end
    @(posedge CLK); #1 b_valid = 0;
    repeat (4) @(negedge CLK);

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
